// File: rtl/calc_scan_display.sv
// Two-operand add/subtract calculator with range-error flag and a time-multiplexed
// common-anode seven-segment driver (one result bit or hex nibble per digit).
module calc_scan_display #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV_BITS = 16,
  parameter int unsigned HEX      = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             op,
  input  logic             calculate,
  input  logic             blank,
  output logic [6:0]       a_to_g,
  output logic [DIGITS-1:0] an,
  output logic [WIDTH:0]   led,
  output logic             err,
  output logic             busy
);

  localparam int unsigned ExtW = 36;

  typedef enum logic [1:0] {StBlank, StCalc, StShow, StErr} state_e;

  state_e              state_q, state_d, shown_q, shown_d, mode;
  logic                calc_q;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic [WIDTH:0]      led_q, led_d, res;
  logic [DIV_BITS-1:0] scan_q, scan_d;
  logic [2:0]          idx_q, idx_d;
  logic                rise, res_err;
  logic [ExtW-1:0]     ext;
  logic [3:0]          digit;

  assign rise    = calculate & ~calc_q;
  assign res     = op_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
  assign res_err = op_q ? (a_q < b_q) : res[WIDTH];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    led_d   = led_q;
    scan_d  = scan_q;
    idx_d   = idx_q;
    if (blank) begin
      state_d = StBlank;
      led_d   = '0;
    end else if (state_q == StCalc) begin
      led_d   = res;
      state_d = res_err ? StErr : StShow;
      scan_d  = '0;
      idx_d   = '0;
    end else if (rise) begin
      a_d     = num1;
      b_d     = num2;
      op_d    = op;
      state_d = StCalc;
    end else if (state_q == StShow) begin
      scan_d = scan_q + DIV_BITS'(1);
      if (&scan_q) begin
        idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
      end
    end
    // Remember what was on screen so CALC keeps showing it.
    shown_d = (state_q == StCalc) ? shown_q : state_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StBlank;
      shown_q <= StBlank;
      calc_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      led_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      calc_q  <= calculate;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      led_q   <= led_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    mode   = (state_q == StCalc) ? shown_q : state_q;
    // Zero-extension makes digits beyond the result width read as 0.
    ext    = ExtW'(led_q);
    digit  = (HEX != 0) ? ext[{idx_q, 2'b00} +: 4] : {3'b000, ext[idx_q]};
    an     = '1;
    a_to_g = 7'b1111111;
    case (mode)
      StShow: begin
        an     = ~(DIGITS'(1) << idx_q);
        a_to_g = seg7(digit);
      end
      StErr: begin
        an     = ~DIGITS'(1);
        a_to_g = 7'b0110000;
      end
      default: ;
    endcase
    led  = led_q;
    err  = (mode == StErr);
    busy = (state_q == StCalc);
  end

endmodule

// File: tb/tb_calc_scan_display.sv
// Scoreboard bench: two calculator instances (bit display and hex display) checked
// every cycle against an arithmetic reference of result, error and scan position.
module tb_calc_scan_display;

  localparam int PW  [2] = '{4, 8};
  localparam int PD  [2] = '{4, 3};
  localparam int PDB [2] = '{2, 1};
  localparam int PHX [2] = '{0, 1};
  localparam int MBlank = 0, MShow = 1, MErr = 2;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic [7:0] n1 [2];
  logic [7:0] n2 [2];
  logic       op [2];
  logic       calc [2];
  logic       blnk [2];

  logic [6:0] seg0, seg1;
  logic [3:0] an0;
  logic [2:0] an1;
  logic [4:0] led0;
  logic [8:0] led1;
  logic       err0, err1, busy0, busy1;

  logic [7:0] an_v [2];
  logic [6:0] seg_v [2];
  logic [8:0] led_v [2];
  logic       err_v [2];
  logic       busy_v [2];

  assign an_v[0]   = {4'b0, an0};
  assign an_v[1]   = {5'b0, an1};
  assign seg_v[0]  = seg0;
  assign seg_v[1]  = seg1;
  assign led_v[0]  = {4'b0, led0};
  assign led_v[1]  = led1;
  assign err_v[0]  = err0;
  assign err_v[1]  = err1;
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;

  calc_scan_display #(.WIDTH(4), .DIGITS(4), .DIV_BITS(2), .HEX(0)) u_bits (
    .clk(clk), .clr_n(clr_n), .num1(n1[0][3:0]), .num2(n2[0][3:0]), .op(op[0]),
    .calculate(calc[0]), .blank(blnk[0]), .a_to_g(seg0), .an(an0), .led(led0),
    .err(err0), .busy(busy0)
  );

  calc_scan_display #(.WIDTH(8), .DIGITS(3), .DIV_BITS(1), .HEX(1)) u_hex (
    .clk(clk), .clr_n(clr_n), .num1(n1[1]), .num2(n2[1]), .op(op[1]),
    .calculate(calc[1]), .blank(blnk[1]), .a_to_g(seg1), .an(an1), .led(led1),
    .err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", name, i, $time, act, exp);
    end
  endtask

  // Reference: {err, result} straight from the arithmetic rules.
  function automatic logic [17:0] model(input int i, input int a, input int b, input bit o);
    int w = PW[i];
    int r;
    bit e;
    if (o) begin
      r = (a - b) & ((1 << (w + 1)) - 1);
      e = (a < b);
    end else begin
      r = a + b;
      e = (r >= (1 << w));
    end
    return {e, 17'(r)};
  endfunction

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Monitor state per instance
  int   mode [2] = '{MBlank, MBlank};
  int   kcnt [2] = '{0, 0};
  int   mres [2] = '{0, 0};
  logic pbusy [2] = '{1'b0, 1'b0};
  logic pblank [2] = '{1'b0, 1'b0};
  logic [17:0] m_e;
  int m_dd, m_v;
  logic [31:0] m_an, m_seg, m_led, m_err, m_mask;
  bit m_empty;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!clr_n) begin
        mode[i] = MBlank;
        mres[i] = 0;
      end else if (pblank[i]) begin
        mode[i] = MBlank;
        mres[i] = 0;
      end else if (busy_v[i]) begin
        // display frozen through the calculation cycle
      end else if (pbusy[i]) begin
        m_empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
        n_vec++;
        if (m_empty) begin
          n_fail++;
          $display("FAIL unexpected_result[%0d] t=%0t got led %h want none", i, $time,
                   led_v[i]);
        end else begin
          m_e = (i == 0) ? q0.pop_front() : q1.pop_front();
          mres[i] = int'(m_e[16:0]);
          mode[i] = m_e[17] ? MErr : MShow;
          kcnt[i] = 0;
        end
      end else if (mode[i] == MShow) begin
        kcnt[i]++;
      end
      m_mask = (1 << PD[i]) - 1;
      case (mode[i])
        MShow: begin
          m_dd  = (kcnt[i] >> PDB[i]) % PD[i];
          m_v   = PHX[i] != 0 ? (mres[i] >> (4 * m_dd)) & 15 : (mres[i] >> m_dd) & 1;
          m_an  = m_mask & ~(32'd1 << m_dd);
          m_seg = 32'(seg_of(m_v));
          m_led = mres[i];
          m_err = 0;
        end
        MErr: begin
          m_an  = m_mask & ~32'd1;
          m_seg = 32'b0110000;
          m_led = mres[i];
          m_err = 1;
        end
        default: begin
          m_an  = m_mask;
          m_seg = 32'h7F;
          m_led = 0;
          m_err = 0;
        end
      endcase
      chk("an", i, 32'(an_v[i]), m_an);
      chk("a_to_g", i, 32'(seg_v[i]), m_seg);
      chk("led", i, 32'(led_v[i]), m_led);
      chk("err", i, 32'(err_v[i]), m_err);
      pbusy[i]  = busy_v[i];
      pblank[i] = blnk[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int i, input logic [17:0] e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Press calculate for one cycle; returns just after the CALC edge.
  task automatic press(input int i, input int a, input int b, input bit o);
    int m = (1 << PW[i]) - 1;
    n1[i]   = 8'(a & m);
    n2[i]   = 8'(b & m);
    op[i]   = o;
    calc[i] = 1'b1;
    push(i, model(i, a & m, b & m, o));
    tick(1);
    calc[i] = 1'b0;
    n1[i]   = 8'($urandom);
    n2[i]   = 8'($urandom);
    op[i]   = 1'($urandom);
    tick(1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      n1[i] = '0; n2[i] = '0; op[i] = 1'b0; calc[i] = 1'b0; blnk[i] = 1'b0;
    end
    #1 clr_n = 1'b0;
    @(posedge clk); #1;
    tick(2);
    clr_n = 1'b1;
    tick(2);

    // Bit display, overflow, subtract
    press(0, 9, 5, 0);  tick(36);
    press(0, 9, 8, 0);  tick(5);
    press(0, 5, 3, 0);  tick(20);
    press(0, 3, 5, 1);  tick(5);
    press(0, 5, 3, 1);  tick(20);
    // Hex display
    press(1, 'hAB, 'h01, 0); tick(14);
    press(1, 'hFF, 'h01, 0); tick(5);

    // Held calculate gives a single calculation
    n1[0] = 8'd2; n2[0] = 8'd7; op[0] = 1'b0; calc[0] = 1'b1;
    push(0, model(0, 2, 7, 0));
    tick(20);
    calc[0] = 1'b0;
    tick(4);

    // blank beats a simultaneous rising edge
    blnk[0] = 1'b1; calc[0] = 1'b1;
    tick(1);
    blnk[0] = 1'b0;
    tick(5);
    calc[0] = 1'b0;
    tick(3);

    // Reset mid-SHOW with calculate high across release
    press(0, 6, 7, 0); tick(4);
    clr_n = 1'b0;
    n1[0] = 8'd4; n2[0] = 8'd3; op[0] = 1'b0; calc[0] = 1'b1;
    push(0, model(0, 4, 3, 0));
    tick(2);
    clr_n = 1'b1;
    tick(1);
    chk("busy_after_release", 0, 32'(busy_v[0]), 32'd1);
    calc[0] = 1'b0;
    tick(6);

    // Randomized traffic
    repeat (60) begin
      int i;
      i = int'($urandom % 2);
      if ($urandom % 6 == 0) begin
        blnk[i] = 1'b1;
        tick(1);
        blnk[i] = 1'b0;
      end else begin
        press(i, int'($urandom % 256), int'($urandom % 256), 1'($urandom));
      end
      tick(int'($urandom % 10));
    end

    tick(40);
    chk("queue_empty", 0, 32'(q0.size()), 32'd0);
    chk("queue_empty", 1, 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
